// File: rtl/uart_operand_rx.sv
// -----------------------------------------------------------------------------
// uart_operand_rx
//
// 8N1 UART receiver that turns each good byte into the two 4-bit adder
// operands: the low nibble becomes operand A, the high nibble operand B.
// The operands hold their value until the next good frame is received.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   rx_in       asynchronous serial line, idle high
//   operand_a   latched low nibble of the last good byte
//   operand_b   latched high nibble of the last good byte
//   data_valid  one-cycle pulse when the operands update
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   busy        high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_operand_rx #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int CNT_W        = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [3:0] operand_a,
    output logic [3:0] operand_b,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    // Mid-bit offset from the start edge and last count of a full bit period.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic             dv_q, dv_d;
    logic             fe_q, fe_d;
    logic             busy_q, busy_d;

    // Two-flop synchronizer; resets to the idle (high) line level so that
    // reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            rx_s_q  <= sync1_q;
        end
    end

    // FSM, datapath and registered output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and output logic. Each state samples rx exactly once per
    // bit, at the point where the bit counter reaches its terminal value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        a_d     = a_q;
        b_d     = b_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_s_q == 1'b0) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q == 1'b1) begin
                        // Line went back high before mid-start: a glitch.
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in at the top and move right.
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q == 1'b1) begin
                        state_d = ST_IDLE;
                        a_d     = shift_q[3:0];
                        b_d     = shift_q[7:4];
                        dv_d    = 1'b1;
                    end else begin
                        // Stop bit low: possibly a break. Wait for the line
                        // to return high so the break is not seen as a start.
                        state_d = ST_WAIT_IDLE;
                        fe_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_IDLE: begin
                if (rx_s_q == 1'b1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = 3'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign operand_a  = a_q;
    assign operand_b  = b_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_operand_rx.sv
module tb_uart_operand_rx;

    localparam int CLKS = 16;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int tests;
    int fails;

    // Monitor state
    int         dv_cnt;
    int         fe_cnt;
    int         both_cnt;
    int         busy_after_bad;
    logic       dv_prev;
    logic [3:0] last_a;
    logic [3:0] last_b;

    uart_operand_rx #(.CLKS_PER_BIT(CLKS), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts pulse cycles and captures operands on each pulse.
    always @(negedge clk) begin
        dv_prev <= data_valid;
        if (data_valid) begin
            dv_cnt <= dv_cnt + 1;
            last_a <= operand_a;
            last_b <= operand_b;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (data_valid && frame_err) both_cnt <= both_cnt + 1;
        if (dv_prev && busy) busy_after_bad <= busy_after_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one full 8N1 frame (start, 8 data bits LSB first, stop).
    task automatic send_frame(input logic [7:0] data, input logic stop);
        rx_in = 1'b0;
        cycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            cycles(CLKS);
        end
        rx_in = stop;
        cycles(CLKS);
    endtask

    initial begin
        int dv0;
        int fe0;
        tests = 0; fails = 0;
        dv_cnt = 0; fe_cnt = 0; both_cnt = 0; busy_after_bad = 0;
        dv_prev = 1'b0; last_a = 4'h0; last_b = 4'h0;
        rx_in = 1'b1;
        rst_n = 1'b0;

        // Reset state
        cycles(3);
        check("reset_a", operand_a, 4'h0);
        check("reset_b", operand_b, 4'h0);
        check("reset_dv", data_valid, 1'b0);
        check("reset_fe", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        cycles(5);

        // Single good frame 0x53
        send_frame(8'h53, 1'b1);
        cycles(4);
        check("f53_dv_cnt", dv_cnt, 1);
        check("f53_a", operand_a, 4'h3);
        check("f53_b", operand_b, 4'h5);
        check("f53_busy_after", busy_after_bad, 0);
        check("f53_busy_idle", busy, 1'b0);

        // 3-cycle glitch while idle
        dv0 = dv_cnt; fe0 = fe_cnt;
        rx_in = 1'b0;
        cycles(3);
        rx_in = 1'b1;
        cycles(3);
        check("glitch_busy_high", busy, 1'b1);
        cycles(8);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_dv", dv_cnt, dv0);
        check("glitch_fe", fe_cnt, fe0);
        check("glitch_a", operand_a, 4'h3);
        check("glitch_b", operand_b, 4'h5);

        // Frame 0xA7 with low stop bit, then line held low (break)
        cycles(5);
        send_frame(8'hA7, 1'b0);
        cycles(40);
        check("ferr_fe_cnt", fe_cnt, fe0 + 1);
        check("ferr_dv_cnt", dv_cnt, dv0);
        check("ferr_a", operand_a, 4'h3);
        check("ferr_b", operand_b, 4'h5);
        check("ferr_busy_held", busy, 1'b1);
        rx_in = 1'b1;
        cycles(5);
        check("ferr_busy_release", busy, 1'b0);
        check("ferr_fe_single", fe_cnt, fe0 + 1);

        // Recovery frame 0x0C
        send_frame(8'h0C, 1'b1);
        cycles(4);
        check("f0c_dv_cnt", dv_cnt, dv0 + 1);
        check("f0c_a", operand_a, 4'hC);
        check("f0c_b", operand_b, 4'h0);

        // Back-to-back 0x21 then 0xFF, no idle gap
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h21, 1'b1);
        check("b2b1_dv", dv_cnt, dv0 + 1);
        check("b2b1_a", last_a, 4'h1);
        check("b2b1_b", last_b, 4'h2);
        send_frame(8'hFF, 1'b1);
        cycles(4);
        check("b2b2_dv", dv_cnt, dv0 + 2);
        check("b2b2_a", operand_a, 4'hF);
        check("b2b2_b", operand_b, 4'hF);
        check("b2b_fe", fe_cnt, fe0);

        // Reset during data bit 4 of 0x99
        dv0 = dv_cnt; fe0 = fe_cnt;
        cycles(3);
        rx_in = 1'b0;
        cycles(CLKS);
        for (int i = 0; i < 4; i++) begin
            rx_in = (8'h99 >> i) & 8'h01;
            cycles(CLKS);
        end
        rx_in = 1'b1;
        cycles(CLKS / 2);
        rst_n = 1'b0;
        #1;
        check("rst_async_a", operand_a, 4'h0);
        check("rst_async_b", operand_b, 4'h0);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_dv", data_valid, 1'b0);
        check("rst_async_fe", frame_err, 1'b0);
        cycles(3);
        rst_n = 1'b1;
        cycles(CLKS * 12);
        check("rst_abort_dv", dv_cnt, dv0);
        check("rst_abort_fe", fe_cnt, fe0);
        send_frame(8'h42, 1'b1);
        cycles(4);
        check("f42_dv", dv_cnt, dv0 + 1);
        check("f42_a", operand_a, 4'h2);
        check("f42_b", operand_b, 4'h4);

        // Sweep of all byte values with random idle gaps
        for (int v = 0; v < 256; v++) begin
            logic [7:0] byte_v;
            byte_v = v[7:0];
            dv0 = dv_cnt;
            cycles($urandom_range(0, 20));
            send_frame(byte_v, 1'b1);
            check("sweep_dv", dv_cnt, dv0 + 1);
            check("sweep_a", last_a, byte_v[3:0]);
            check("sweep_b", last_b, byte_v[7:4]);
        end
        cycles(4);
        check("sweep_fe_none", fe_cnt, fe0);
        check("never_both", both_cnt, 0);
        check("busy_after_pulse", busy_after_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
